// File: rtl/demux1_4_64_buf_pkg.sv
// Shared definitions for the buffered 1:4 distributor (demux1_4_64_buf).
// Optional statistics counters are enabled with the DEMUX_STATS_EN macro.
package demux_pkg;

    localparam int NLANES = 4;
    localparam int STAT_W = 16;

    typedef logic [1:0] lane_sel_t;

    // Occupancy class of one lane FIFO
    typedef enum logic [1:0] {
        LANE_EMPTY   = 2'd0,
        LANE_PARTIAL = 2'd1,
        LANE_FULL    = 2'd2
    } lane_state_t;

    // Increment that sticks at all-ones instead of wrapping to zero
    function automatic logic [STAT_W-1:0] satIncr(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/demux1_4_64_buf_if.sv
// Producer/consumer bus of the buffered 1:4 distributor.
// The xfer_cnt signals only exist when DEMUX_STATS_EN is defined.
interface demux1_4_64_buf_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    lane_sel_t         in_sel;
    logic [NLANES-1:0] out_valid;
    logic [NLANES-1:0] out_ready;
    logic [WIDTH-1:0]  out_data [NLANES];
`ifdef DEMUX_STATS_EN
    logic [STAT_W-1:0] xfer_cnt [NLANES];

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, xfer_cnt
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, xfer_cnt
    );
`else
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/demux1_4_64_buf_lane_fifo.sv
// One lane of the distributor: a small circular FIFO with registered
// full/empty so the producer-side ready never sees the consumer's ready.
module lane_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    lane_state_t      w_state;
    logic             w_doPush;
    logic             w_doPop;

    // Classify occupancy from the registered count
    always_comb begin
        w_state = LANE_PARTIAL;
        if (r_count == '0) begin
            w_state = LANE_EMPTY;
        end else if (r_count == CNT_W'(DEPTH)) begin
            w_state = LANE_FULL;
        end
    end

    assign o_full   = (w_state == LANE_FULL);
    assign o_empty  = (w_state == LANE_EMPTY);
    assign o_head   = r_mem[r_rptr];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Storage array; contents need no reset since empty lanes are never shown valid
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/demux1_4_64_buf.sv
// Buffered 1:4 distributor: routes one word per cycle into one of four
// independent lane FIFOs. Per-lane accepted-word counters are built only
// when DEMUX_STATS_EN is defined.
module demux1_4_64_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input logic              clk,
    input logic              reset,
    demux1_4_64_buf_if.slave bus
);
    logic [NLANES-1:0] w_full;
    logic [NLANES-1:0] w_empty;
    logic [NLANES-1:0] w_push;
    logic [NLANES-1:0] w_pop;
    logic [WIDTH-1:0]  w_head [NLANES];

    assign bus.in_ready  = !w_full[bus.in_sel];
    assign bus.out_valid = ~w_empty;
    assign w_pop         = ~w_empty & bus.out_ready;

    // One-hot push strobe for the selected lane on an accepted transfer
    always_comb begin
        w_push = '0;
        if (bus.in_valid && bus.in_ready) begin
            w_push[bus.in_sel] = 1'b1;
        end
    end

    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
        lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[gi]),
            .i_pop   (w_pop[gi]),
            .i_data  (bus.in_data),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi]),
            .o_head  (w_head[gi])
        );
        assign bus.out_data[gi] = w_head[gi];
    end

`ifdef DEMUX_STATS_EN
    logic [STAT_W-1:0] r_xferCnt [NLANES];

    // Count accepted pushes per lane, holding at the maximum instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NLANES; n++) begin
                r_xferCnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NLANES; n++) begin
                if (w_push[n]) begin
                    r_xferCnt[n] <= satIncr(r_xferCnt[n]);
                end
            end
        end
    end

    for (genvar gs = 0; gs < NLANES; gs++) begin : g_stat
        assign bus.xfer_cnt[gs] = r_xferCnt[gs];
    end
`endif

endmodule

// File: tb/tb_demux1_4_64_buf.sv
// Self-checking bench for demux1_4_64_buf. Every cycle the outputs are
// compared with a queue-per-lane reference model; directed tables and
// sequences cover the corner cases. DEMUX_STATS_EN adds counter checks.
module tb_demux1_4_64_buf;
    import demux_pkg::*;

    localparam int WIDTH = 64;
    localparam int DEPTH = 2;

    logic clk;
    logic reset;

    demux1_4_64_buf_if #(.WIDTH(WIDTH)) bus ();

    demux1_4_64_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int assertCount = 0;
    int failCount   = 0;

    logic [WIDTH-1:0] modelQ [NLANES][$];
    int               xferModel [NLANES];
    bit               captureEn = 1'b0;
    logic [WIDTH-1:0] gotQ [$];
    bit               lastAccept;

    typedef struct {
        bit               valid;
        lane_sel_t        sel;
        logic [WIDTH-1:0] data;
        logic [3:0]       ordy;
        logic [3:0]       expValid;
        bit               expReady;
        int               chkLane;
        logic [WIDTH-1:0] expData;
    } vec_t;

    vec_t vecs [7];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports
    task automatic compare(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive producer and consumer inputs
    task automatic applyStimulus(input bit valid, input lane_sel_t sel, input logic [WIDTH-1:0] data, input logic [3:0] ordy);
        bus.in_valid  = valid;
        bus.in_sel    = sel;
        bus.in_data   = data;
        bus.out_ready = ordy;
    endtask

    function automatic void clearModel();
        for (int n = 0; n < NLANES; n++) begin
            modelQ[n].delete();
            xferModel[n] = 0;
        end
    endfunction

    // Check ready before the edge, advance model across the edge, check lanes after it
    task automatic checkOutput(input string tag);
        bit expReady;
        bit popIt [NLANES];
        #1;
        expReady = (modelQ[bus.in_sel].size() < DEPTH);
        compare({tag, ".in_ready"}, {63'd0, bus.in_ready}, {63'd0, expReady});
        if (captureEn && bus.out_valid[0] && bus.out_ready[0]) begin
            gotQ.push_back(bus.out_data[0]);
        end
        @(posedge clk);
        for (int n = 0; n < NLANES; n++) begin
            popIt[n] = (modelQ[n].size() > 0) && bus.out_ready[n];
        end
        for (int n = 0; n < NLANES; n++) begin
            if (popIt[n]) void'(modelQ[n].pop_front());
        end
        lastAccept = bus.in_valid && expReady;
        if (lastAccept) begin
            modelQ[bus.in_sel].push_back(bus.in_data);
            if (xferModel[bus.in_sel] < 65535) xferModel[bus.in_sel]++;
        end
        #1;
        for (int n = 0; n < NLANES; n++) begin
            compare($sformatf("%s.out_valid[%0d]", tag, n), {63'd0, bus.out_valid[n]},
                    {63'd0, modelQ[n].size() > 0});
            if (modelQ[n].size() > 0) begin
                compare($sformatf("%s.out_data[%0d]", tag, n), bus.out_data[n], modelQ[n][0]);
            end
`ifdef DEMUX_STATS_EN
            compare($sformatf("%s.xfer_cnt[%0d]", tag, n), {48'd0, bus.xfer_cnt[n]}, WIDTH'(xferModel[n]));
`endif
        end
    endtask

    initial begin
        logic [WIDTH-1:0] b2bData [4];
        logic [WIDTH-1:0] expOrder [$];
        int               guard;
        bit               holdValid;

        // Directed table: reset, single push, stall/order on lane 1, drain
        vecs[0] = '{1'b1, 2'd2, 64'd5,  4'b0000, 4'b0100, 1'b1, 2,  64'd5};
        vecs[1] = '{1'b1, 2'd1, 64'd10, 4'b0000, 4'b0110, 1'b1, 1,  64'd10};
        vecs[2] = '{1'b1, 2'd1, 64'd20, 4'b0000, 4'b0110, 1'b0, 1,  64'd10};
        vecs[3] = '{1'b1, 2'd3, 64'd99, 4'b0000, 4'b1110, 1'b1, 3,  64'd99};
        vecs[4] = '{1'b0, 2'd1, 64'd0,  4'b0010, 4'b1110, 1'b1, 1,  64'd20};
        vecs[5] = '{1'b0, 2'd1, 64'd0,  4'b0010, 4'b1100, 1'b1, 2,  64'd5};
        vecs[6] = '{1'b0, 2'd0, 64'd0,  4'b1111, 4'b0000, 1'b1, -1, 64'd0};

        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, '0, 4'b0000);
        clearModel();
        #3;
        compare("reset.out_valid", {60'd0, bus.out_valid}, 64'd0);
        compare("reset.in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] Directed table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            checkOutput($sformatf("vec%0d", i));
            compare($sformatf("vec%0d.tbl_valid", i), {60'd0, bus.out_valid}, {60'd0, vecs[i].expValid});
            compare($sformatf("vec%0d.tbl_ready", i), {63'd0, bus.in_ready}, {63'd0, vecs[i].expReady});
            if (vecs[i].chkLane >= 0) begin
                compare($sformatf("vec%0d.tbl_data", i), bus.out_data[vecs[i].chkLane], vecs[i].expData);
            end
        end

        $display("[TB] Full lane with simultaneous pop");
        applyStimulus(1'b1, 2'd0, 64'hA0, 4'b0000);
        checkOutput("fill0");
        applyStimulus(1'b1, 2'd0, 64'hA1, 4'b0000);
        checkOutput("fill1");
        applyStimulus(1'b1, 2'd0, 64'hA2, 4'b0001);
        #1;
        compare("fullpop.pre_ready", {63'd0, bus.in_ready}, 64'd0);
        checkOutput("fullpop");
        compare("fullpop.head", bus.out_data[0], 64'hA1);
        compare("fullpop.ready_after", {63'd0, bus.in_ready}, 64'd1);
        applyStimulus(1'b1, 2'd0, 64'hA2, 4'b0000);
        checkOutput("fullpop.retry");

        $display("[TB] Eight words through lane 0 with random stalls");
        expOrder.delete();
        expOrder.push_back(64'hA1);
        expOrder.push_back(64'hA2);
        gotQ.delete();
        captureEn = 1'b1;
        for (int w = 0; w < 8; w++) begin
            expOrder.push_back(64'hB0 + WIDTH'(w));
            guard = 0;
            do begin
                applyStimulus(1'b1, 2'd0, 64'hB0 + WIDTH'(w), {3'b000, 1'($urandom_range(0, 1))});
                checkOutput("wrap.push");
                guard++;
            end while (!lastAccept && guard < 50);
            if (!lastAccept) compare("wrap.accept_timeout", 64'd0, 64'd1);
        end
        for (int d = 0; d < 6; d++) begin
            applyStimulus(1'b0, 2'd0, '0, 4'b0001);
            checkOutput("wrap.drain");
        end
        captureEn = 1'b0;
        compare("wrap.count", WIDTH'(gotQ.size()), WIDTH'(expOrder.size()));
        for (int k = 0; k < expOrder.size() && k < gotQ.size(); k++) begin
            compare($sformatf("wrap.order%0d", k), gotQ[k], expOrder[k]);
        end

        $display("[TB] Back-to-back pushes to all lanes");
        b2bData[0] = 64'd5;
        b2bData[1] = 64'd2;
        b2bData[2] = 64'd10;
        b2bData[3] = 64'd20;
        for (int n = 0; n < NLANES; n++) begin
            applyStimulus(1'b1, lane_sel_t'(n), b2bData[n], 4'b1111);
            checkOutput("b2b");
            compare($sformatf("b2b.valid%0d", n), {60'd0, bus.out_valid}, 64'd1 << n);
            compare($sformatf("b2b.data%0d", n), bus.out_data[n], b2bData[n]);
        end
        applyStimulus(1'b0, 2'd0, '0, 4'b1111);
        checkOutput("b2b.idle");
        compare("b2b.final", {60'd0, bus.out_valid}, 64'd0);

        $display("[TB] Reset with lanes 1 and 3 partially filled");
        applyStimulus(1'b1, 2'd1, 64'h111, 4'b0000);
        checkOutput("prerst1");
        applyStimulus(1'b1, 2'd3, 64'h333, 4'b0000);
        checkOutput("prerst3");
        reset = 1'b1;
        #2;
        compare("midrst.out_valid", {60'd0, bus.out_valid}, 64'd0);
        compare("midrst.in_ready", {63'd0, bus.in_ready}, 64'd1);
        clearModel();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 2'd1, '0, 4'b0000);
            checkOutput("postrst");
        end

        $display("[TB] Randomized traffic");
        holdValid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!holdValid) begin
                applyStimulus(1'($urandom_range(0, 3) != 0), lane_sel_t'($urandom_range(0, 3)),
                              {$urandom, $urandom}, 4'($urandom));
            end else begin
                bus.out_ready = 4'($urandom);
            end
            checkOutput("rand");
            holdValid = bus.in_valid && !lastAccept;
        end

`ifdef DEMUX_STATS_EN
        $display("[TB] Saturating transfer counters");
        applyStimulus(1'b0, 2'd0, '0, 4'b1111);
        reset = 1'b1;
        #2;
        clearModel();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            applyStimulus(1'b1, 2'd0, WIDTH'(c), 4'b1111);
            checkOutput("stats");
        end
        compare("stats.lane0", {48'd0, bus.xfer_cnt[0]}, 64'hFFFF);
        compare("stats.lane1", {48'd0, bus.xfer_cnt[1]}, 64'd0);
        compare("stats.lane2", {48'd0, bus.xfer_cnt[2]}, 64'd0);
        compare("stats.lane3", {48'd0, bus.xfer_cnt[3]}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
